control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/ir_decode.sv | 27 ++
 rtl/control_sequencer.sv | 179 +++++++++++++++++
 tb/tb_control_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared state encoding, opcode constants and IR field positions for the control sequencer.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_HALT,
    ST_FAULT
  } state_t;

  localparam logic [4:0] ALU_INC      = 5'd12;
  localparam logic [4:0] HALT_OP      = 5'd27;
  localparam logic [4:0] OP_LEGAL_MIN = 5'd3;
  localparam logic [4:0] OP_LEGAL_MAX = 5'd10;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

endpackage

// File: rtl/ir_decode.sv
// Purely combinational IR field splitter with halt/legal opcode classification.
// Zero latency; no flow control.
module ir_decode
  import cpu_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [3:0]  o_ra,
  output logic [3:0]  o_rb,
  output logic [3:0]  o_rc,
  output logic [4:0]  o_opcode,
  output logic        o_is_halt,
  output logic        o_is_legal
);

  logic w_unused;

  assign o_opcode   = i_ir[IR_OP_HI:IR_OP_LO];
  assign o_ra       = i_ir[IR_RA_HI:IR_RA_LO];
  assign o_rb       = i_ir[IR_RB_HI:IR_RB_LO];
  assign o_rc       = i_ir[IR_RC_HI:IR_RC_LO];
  assign o_is_halt  = (o_opcode == HALT_OP);
  assign o_is_legal = (o_opcode >= OP_LEGAL_MIN) && (o_opcode <= OP_LEGAL_MAX);

  // Low IR bits carry immediates consumed by the datapath, not by sequencing.
  assign w_unused = ^i_ir[IR_RC_LO-1:0];

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: one state per clk, strobes decoded from state (T3-T5 also use ir fields).
// No backpressure; run gates instruction start. Define SINGLE_STEP_EN to add the step input and single-step mode.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Read,
  output logic [4:0]  OpCode,
  output logic        Rout_en,
  output logic        Rin_en,
  output logic [3:0]  Rout_sel,
  output logic [3:0]  Rin_sel,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [15:0] inst_count
);

  state_t      r_state;
  logic [15:0] r_inst_count;
  logic        r_busy;
  logic        r_halted;
  logic        r_fault;

  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic [4:0]  w_opcode;
  logic        w_is_halt;
  logic        w_is_legal;
  logic        w_start;
  logic        w_again;

  ir_decode u_ir_decode (
    .i_ir       (ir),
    .o_ra       (w_ra),
    .o_rb       (w_rb),
    .o_rc       (w_rc),
    .o_opcode   (w_opcode),
    .o_is_halt  (w_is_halt),
    .o_is_legal (w_is_legal)
  );

`ifdef SINGLE_STEP_EN
  assign w_start = run & step;
  assign w_again = 1'b0;
`else
  assign w_start = run;
  assign w_again = run;
`endif

  // busy/halted/fault are registered alongside the state transition that implies them.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state      <= ST_IDLE;
      r_inst_count <= 16'd0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_T0;
            r_busy  <= 1'b1;
          end
        end
        ST_T0: r_state <= ST_T1;
        ST_T1: r_state <= ST_T2;
        ST_T2: r_state <= ST_T3;
        ST_T3: begin
          if (w_is_halt) begin
            r_state  <= ST_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else if (!w_is_legal) begin
            r_state <= ST_FAULT;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
          end else begin
            r_state <= ST_T4;
          end
        end
        ST_T4: r_state <= ST_T5;
        ST_T5: begin
          r_inst_count <= r_inst_count + 16'd1;
          if (w_again) begin
            r_state <= ST_T0;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_HALT, ST_FAULT: r_state <= r_state;
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Read     = 1'b0;
    OpCode   = 5'd0;
    Rout_en  = 1'b0;
    Rin_en   = 1'b0;
    Rout_sel = 4'd0;
    Rin_sel  = 4'd0;
    case (r_state)
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        Zin    = 1'b1;
        OpCode = ALU_INC;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        // Halt is outside the legal range, so one test silences both exit paths.
        if (w_is_legal) begin
          Rout_en  = 1'b1;
          Rout_sel = w_rb;
          Yin      = 1'b1;
        end
      end
      ST_T4: begin
        Rout_en  = 1'b1;
        Rout_sel = w_rc;
        Zin      = 1'b1;
        OpCode   = w_opcode;
      end
      ST_T5: begin
        Zlowout = 1'b1;
        Rin_en  = 1'b1;
        Rin_sel = w_ra;
      end
      default: ;
    endcase
  end

  assign busy       = r_busy;
  assign halted     = r_halted;
  assign fault      = r_fault;
  assign inst_count = r_inst_count;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: phase-level model of the sequencer compared every cycle, plus literal spot checks.
module tb_control_sequencer;

  typedef struct packed {
    logic        PCout;
    logic        Zlowout;
    logic        MDRout;
    logic        MARin;
    logic        Zin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Read;
    logic [4:0]  OpCode;
    logic        Rout_en;
    logic [3:0]  Rout_sel;
    logic        Rin_en;
    logic [3:0]  Rin_sel;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [15:0] inst_count;
  } obs_t;

  logic        clk;
  logic        clr;
  logic        run;
  logic [31:0] ir;
`ifdef SINGLE_STEP_EN
  logic        step;
`endif
  obs_t        obs;

  control_sequencer dut (
    .clk        (clk),
    .clr        (clr),
    .run        (run),
`ifdef SINGLE_STEP_EN
    .step       (step),
`endif
    .ir         (ir),
    .PCout      (obs.PCout),
    .Zlowout    (obs.Zlowout),
    .MDRout     (obs.MDRout),
    .MARin      (obs.MARin),
    .Zin        (obs.Zin),
    .PCin       (obs.PCin),
    .MDRin      (obs.MDRin),
    .IRin       (obs.IRin),
    .Yin        (obs.Yin),
    .Read       (obs.Read),
    .OpCode     (obs.OpCode),
    .Rout_en    (obs.Rout_en),
    .Rin_en     (obs.Rin_en),
    .Rout_sel   (obs.Rout_sel),
    .Rin_sel    (obs.Rin_sel),
    .busy       (obs.busy),
    .halted     (obs.halted),
    .fault      (obs.fault),
    .inst_count (obs.inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model phases: 0 idle, 1..6 = T0..T5, 7 halt, 8 fault.
  int          m_phase;
  logic [15:0] m_count;
  bit          m_valid;
  int          n_chk;
  int          n_fail;
  int          n_cyc;
  obs_t        snap;
  obs_t        ph_snap [0:8];

  function automatic obs_t expect_obs(int ph, logic [31:0] iv, logic [15:0] cnt);
    obs_t       e;
    logic [4:0] opc;
    e = '0;
    opc = iv[31:27];
    e.inst_count = cnt;
    e.busy   = (ph >= 1 && ph <= 6);
    e.halted = (ph == 7);
    e.fault  = (ph == 8);
    case (ph)
      1: begin e.PCout = 1'b1; e.MARin = 1'b1; e.Zin = 1'b1; e.OpCode = 5'd12; end
      2: begin e.Zlowout = 1'b1; e.PCin = 1'b1; e.Read = 1'b1; e.MDRin = 1'b1; end
      3: begin e.MDRout = 1'b1; e.IRin = 1'b1; end
      4: if (opc >= 5'd3 && opc <= 5'd10) begin
           e.Rout_en = 1'b1; e.Rout_sel = iv[22:19]; e.Yin = 1'b1;
         end
      5: begin e.Rout_en = 1'b1; e.Rout_sel = iv[18:15]; e.Zin = 1'b1; e.OpCode = opc; end
      6: begin e.Zlowout = 1'b1; e.Rin_en = 1'b1; e.Rin_sel = iv[26:23]; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_step();
    logic [4:0] opc;
    logic       go;
    opc = ir[31:27];
`ifdef SINGLE_STEP_EN
    go = run & step;
`else
    go = run;
`endif
    if (!clr) begin
      m_valid = 1'b1;
      m_phase = 0;
      m_count = 16'd0;
    end else if (m_phase == 0) begin
      if (go) m_phase = 1;
    end else if (m_phase >= 1 && m_phase <= 3) begin
      m_phase = m_phase + 1;
    end else if (m_phase == 4) begin
      if (opc == 5'd27)                    m_phase = 7;
      else if (opc < 5'd3 || opc > 5'd10)  m_phase = 8;
      else                                 m_phase = 5;
    end else if (m_phase == 5) begin
      m_phase = 6;
    end else if (m_phase == 6) begin
      m_count = m_count + 16'd1;
`ifdef SINGLE_STEP_EN
      m_phase = 0;
`else
      m_phase = run ? 1 : 0;
`endif
    end
  endtask

  // Apply inputs for one cycle, compare at the falling edge, advance the model at the rising edge.
  task automatic cyc(input logic c, input logic r, input logic [31:0] i);
    obs_t e;
    int   p;
    clr = c;
    run = r;
    ir  = i;
    @(negedge clk);
    n_cyc++;
    if (m_valid) begin
      e = expect_obs(m_phase, ir, m_count);
      n_chk++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL cycle%0d phase%0d outputs: got %h want %h", n_cyc, m_phase, obs, e);
      end
    end
    snap = obs;
    p = m_phase;
    @(posedge clk);
    model_step();
    #2;
    if (p >= 0 && p <= 8) ph_snap[p] = snap;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // One instruction; run is dropped mid-instruction and only keep_run is offered in T5.
  task automatic run_instr(input logic [31:0] instr, input logic keep_run, input int stop_ph);
    int          p;
    logic        r;
    logic [31:0] g;
    for (int k = 0; k < 12; k++) begin
      p = m_phase;
      if (p == stop_ph) begin
        cyc(1'b0, 1'b0, instr);
        return;
      end
      r = (p == 0) ? 1'b1 : ((p == 6) ? keep_run : 1'b0);
      g = $urandom;
      cyc(1'b1, r, (p >= 1 && p <= 3) ? g : instr);
      if (p == 6 || m_phase >= 7) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL run_instr timeout: got phase %0d want instruction end", m_phase);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
  endtask

  localparam logic [31:0] I_LEGAL = 32'h28918000;
  localparam logic [31:0] I_LO    = {5'd3, 4'd4, 4'd5, 4'd6, 15'h0};
  localparam logic [31:0] I_HI    = {5'd10, 4'd15, 4'd0, 4'd9, 15'h7FFF};
  localparam logic [31:0] I_HALT  = {5'd27, 4'd1, 4'd2, 4'd3, 15'h0};
  localparam logic [31:0] I_BAD   = {5'd31, 4'd7, 4'd7, 4'd7, 15'h0};
  localparam logic [31:0] I_BELOW = {5'd2, 4'd1, 4'd1, 4'd1, 15'h0};
  localparam logic [31:0] I_ABOVE = {5'd11, 4'd1, 4'd1, 4'd1, 15'h0};

  initial begin
    n_chk = 0; n_fail = 0; n_cyc = 0;
    m_valid = 1'b0; m_phase = 0; m_count = 16'd0;
    clr = 1'b1; run = 1'b0; ir = 32'd0;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    for (int k = 0; k < 9; k++) ph_snap[k] = '0;

    // Reset state
    do_reset();
    cyc(1'b1, 1'b0, 32'd0);
    lit("reset_outputs", {12'd0, snap}, 44'd0);

    // Single legal instruction, then idle
    run_instr(I_LEGAL, 1'b0, -1);
    lit("t3_rout_sel", {28'd0, ph_snap[4].Rout_sel}, 32'd2);
    lit("t3_yin", {31'd0, ph_snap[4].Yin}, 32'd1);
    lit("t4_rout_sel", {28'd0, ph_snap[5].Rout_sel}, 32'd3);
    lit("t4_opcode", {27'd0, ph_snap[5].OpCode}, 32'd5);
    lit("t5_rin_sel", {28'd0, ph_snap[6].Rin_sel}, 32'd1);
    lit("t5_zlowout", {31'd0, ph_snap[6].Zlowout}, 32'd1);
    lit("count_after_one", {16'd0, obs.inst_count}, 32'd1);
    lit("idle_after_one", {31'd0, obs.busy}, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);

    // Back-to-back with boundary opcodes
    do_reset();
    run_instr(I_LO, 1'b1, -1);
`ifndef SINGLE_STEP_EN
    lit("b2b_direct_t0", {31'd0, obs.PCout}, 32'd1);
`endif
    run_instr(I_HI, 1'b1, -1);
    run_instr(I_LEGAL, 1'b0, -1);
    lit("b2b_count", {16'd0, obs.inst_count}, 32'd3);
    cyc(1'b1, 1'b0, 32'd0);

    // Halt holds regardless of run
    run_instr(I_HALT, 1'b0, -1);
    lit("halt_t3_quiet", {31'd0, ph_snap[4].Rout_en | ph_snap[4].Yin}, 32'd0);
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, $urandom);
    lit("halt_held", {29'd0, obs.halted, obs.busy, obs.Rin_en}, 32'd4);
    lit("halt_count", {16'd0, obs.inst_count}, 32'd3);

    // Illegal opcodes fault; clr recovers
    do_reset();
    run_instr(I_BAD, 1'b0, -1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 32'd0);
    lit("fault_set", {31'd0, obs.fault}, 32'd1);
    cyc(1'b0, 1'b1, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    lit("fault_cleared", {30'd0, obs.fault, obs.busy}, 32'd0);
    run_instr(I_BELOW, 1'b0, -1);
    cyc(1'b1, 1'b0, 32'd0);
    do_reset();
    run_instr(I_ABOVE, 1'b0, -1);
    cyc(1'b1, 1'b0, 32'd0);

    // clr falling during T4 aborts and clears the count
    do_reset();
    run_instr(I_LEGAL, 1'b0, -1);
    run_instr(I_LO, 1'b0, 5);
    lit("midop_count", {16'd0, obs.inst_count}, 32'd0);
    lit("midop_idle", {31'd0, obs.busy}, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);

    // Counter wrap, starting from a preloaded all-ones count
    force dut.r_inst_count = 16'hFFFF;
    m_count = 16'hFFFF;
    cyc(1'b1, 1'b0, 32'd0);
    release dut.r_inst_count;
    cyc(1'b1, 1'b0, 32'd0);
    run_instr(I_HI, 1'b0, -1);
    lit("wrap_before", {16'd0, ph_snap[6].inst_count}, 32'hFFFF);
    lit("wrap_after", {16'd0, obs.inst_count}, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
